// File: rtl/gp_mem_pkg.sv
// Shared types and constants for the GP-Core memory arbiter.
// Used by the arbiter top and its winner-select helper.
package gp_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [3:0] I_BE_LO = 4'b0011;
   localparam logic [3:0] I_BE_HI = 4'b1100;

   localparam int STARVE_W = 4;
   localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

endpackage

// File: rtl/gp_mem_arb_pick.sv
// Combinational winner select: data side wins unless the instruction
// side has been starved for too long.
module gp_mem_arb_pick
   import gp_mem_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
   input  logic   starve_sat,
   output logic   grant,
   output owner_t winner
);

   always_comb begin
      grant  = i_req | d_req;
      winner = (d_req && !(i_req && starve_sat)) ? OWN_D : OWN_I;
   end

endmodule

// File: rtl/gp_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the GP-Core
// fetch side (16-bit words) and data side (32-bit words).
module gp_mem_arbiter
   import gp_mem_pkg::*;
#(
   parameter logic [31:0] I_BASE       = 32'h0000_0000,
   parameter int          STARVE_LIMIT = 4,
   parameter int          TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic [15:0] i_rdata,
   output logic        i_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err,
   output logic        gnt_d
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);
   localparam logic [7:0]          TMO_LAST   = 8'(TIMEOUT - 1);

   arb_state_t           state_q, state_d;
   owner_t               owner_q, owner_d;
   logic [31:0]          addr_q, addr_d;
   logic [3:0]           be_q, be_d;
   logic                 we_q, we_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 i_sel_q, i_sel_d;
   logic [STARVE_W-1:0]  starve_q, starve_d;
   logic [7:0]           tmo_q, tmo_d;
   logic                 bus_err_q, bus_err_d;

   logic   grant;
   owner_t winner;
   logic   starve_sat;

   assign starve_sat = (starve_q >= STARVE_LIM);

   gp_mem_arb_pick u_pick (
      .i_req      (i_req),
      .d_req      (d_req),
      .starve_sat (starve_sat),
      .grant      (grant),
      .winner     (winner)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      be_d      = be_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      i_sel_d   = i_sel_q;
      starve_d  = starve_q;
      tmo_d     = tmo_q;
      bus_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (grant) begin
               state_d = BUSY;
               owner_d = winner;
               if (winner == OWN_D) begin
                  addr_d  = d_addr;
                  be_d    = d_be;
                  we_d    = d_we;
                  wdata_d = d_wdata;
                  if (i_req) begin
                     starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
                  end
               end else begin
                  addr_d   = {I_BASE[31:17], i_addr, 1'b0};
                  be_d     = i_addr[0] ? I_BE_HI : I_BE_LO;
                  we_d     = 1'b0;
                  wdata_d  = '0;
                  i_sel_d  = i_addr[0];
                  starve_d = '0;
               end
            end
         end
         BUSY: begin
            // An ack on the final allowed cycle still counts as a normal completion.
            if (mem_ack) begin
               rdata_d = we_q ? 32'h0 : mem_rdata;
               state_d = RESP;
            end else if (tmo_q == TMO_LAST) begin
               rdata_d   = '0;
               bus_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         RESP: begin
            tmo_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_I;
         addr_q    <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         i_sel_q   <= 1'b0;
         starve_q  <= '0;
         tmo_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         i_sel_q   <= i_sel_d;
         starve_q  <= starve_d;
         tmo_q     <= tmo_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      mem_req   = (state_q == BUSY);
      mem_we    = we_q;
      mem_be    = be_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      i_ready   = (state_q == RESP) && (owner_q == OWN_I);
      d_ready   = (state_q == RESP) && (owner_q == OWN_D);
      i_rdata   = i_ready ? (i_sel_q ? rdata_q[31:16] : rdata_q[15:0]) : 16'h0;
      d_rdata   = d_ready ? rdata_q : 32'h0;
      bus_err   = bus_err_q;
      gnt_d     = (owner_q == OWN_D);
   end

endmodule

// File: tb/tb_gp_mem_arbiter.sv
// Directed bench for gp_mem_arbiter: a vector table of lone transactions
// plus hand-written sequences for priority, starvation, timeout and reset.
module tb_gp_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic [15:0] i_rdata;
   logic        i_ready;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;
   logic        gnt_d;

   int totalChecks;
   int passedChecks;

   gp_mem_arbiter #(
      .I_BASE       (32'h0000_0000),
      .STARVE_LIMIT (4),
      .TIMEOUT      (255)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ready   (i_ready),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err),
      .gnt_d     (gnt_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One lone transaction with hand-computed expectations.
   typedef struct {
      bit          is_d;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [15:0] iaddr;
      logic [31:0] mrdata;
      int          delay;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      bit          exp_we;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalChecks++;
      if (act === exp) passedChecks++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic boundExpired(input string name);
      totalChecks++;
      $display("[TB] FAIL %s: got no response expected response within bound", name);
   endtask

   // Runs one vector from IDLE, acting as the memory with the vector's ack delay.
   task automatic applyStimulus(input vec_t v, input int idx);
      int busy;
      int lat;
      bit done;
      busy = 0;
      lat  = 0;
      done = 0;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.iaddr;
      end
      mem_rdata = v.mrdata;
      for (int c = 0; c < 30 && !done; c++) begin
         step();
         lat++;
         mem_ack = 1'b0;
         if (mem_req) begin
            if (busy == 0) begin
               checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
               checkOutput($sformatf("v%0d mem_be", idx), {28'h0, mem_be}, {28'h0, v.exp_be});
               checkOutput($sformatf("v%0d mem_we", idx), {31'h0, mem_we}, {31'h0, v.exp_we});
               checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
               checkOutput($sformatf("v%0d gnt_d", idx), {31'h0, gnt_d}, {31'h0, v.is_d});
            end
            busy++;
            if (busy == v.delay + 1) mem_ack = 1'b1;
         end
         if (i_ready || d_ready) begin
            done = 1;
            checkOutput($sformatf("v%0d d_ready", idx), {31'h0, d_ready}, {31'h0, v.is_d});
            checkOutput($sformatf("v%0d i_ready", idx), {31'h0, i_ready}, {31'h0, !v.is_d});
            if (v.is_d) checkOutput($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_rdata);
            else        checkOutput($sformatf("v%0d i_rdata", idx), {16'h0, i_rdata}, v.exp_rdata);
            checkOutput($sformatf("v%0d latency", idx), lat, v.delay + 2);
            i_req = 1'b0;
            d_req = 1'b0;
         end
      end
      if (!done) boundExpired($sformatf("v%0d ready", idx));
      step();
   endtask

   // Acks the next grant immediately and returns which side owned it.
   task automatic serveOne(output bit wasD, output bit ok);
      bit acked;
      acked = 0;
      ok    = 0;
      wasD  = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         step();
         mem_ack = 1'b0;
         if (mem_req && !acked) begin
            wasD    = gnt_d;
            mem_ack = 1'b1;
            acked   = 1;
         end
         if (i_ready || d_ready) ok = 1;
      end
   endtask

   initial begin
      bit wasD;
      bit ok;
      int cnt;
      int busy;
      int readies;
      bit fell;

      totalChecks  = 0;
      passedChecks = 0;
      rst = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;

      // Fields: is_d, we, be, addr, wdata, iaddr, mrdata, delay, exp_addr, exp_be, exp_we, exp_wdata, exp_rdata
      vecs[0] = '{0, 0, 4'h0, 32'h0,         32'h0,         16'h0005, 32'hBEEF_1234, 0, 32'h0000_000A, 4'b1100, 0, 32'h0,         32'h0000_BEEF};
      vecs[1] = '{0, 0, 4'h0, 32'h0,         32'h0,         16'h1234, 32'hAAAA_5555, 2, 32'h0000_2468, 4'b0011, 0, 32'h0,         32'h0000_5555};
      vecs[2] = '{1, 0, 4'hF, 32'h0000_0400, 32'h1111_2222, 16'h0,    32'h1357_9BDF, 1, 32'h0000_0400, 4'hF,    0, 32'h1111_2222, 32'h1357_9BDF};
      vecs[3] = '{1, 1, 4'hF, 32'h0000_0100, 32'hCAFE_F00D, 16'h0,    32'hFFFF_FFFF, 0, 32'h0000_0100, 4'hF,    1, 32'hCAFE_F00D, 32'h0};
      vecs[4] = '{1, 1, 4'h6, 32'h8000_0004, 32'h0102_0304, 16'h0,    32'h5A5A_5A5A, 3, 32'h8000_0004, 4'h6,    1, 32'h0102_0304, 32'h0};
      vecs[5] = '{0, 0, 4'h0, 32'h0,         32'h0,         16'hFFFF, 32'h8001_7FFE, 1, 32'h0001_FFFE, 4'b1100, 0, 32'h0,         32'h0000_8001};

      step();
      step();
      checkOutput("reset mem_req", {31'h0, mem_req}, 32'h0);
      checkOutput("reset mem_addr", mem_addr, 32'h0);
      checkOutput("reset i_ready", {31'h0, i_ready}, 32'h0);
      checkOutput("reset d_ready", {31'h0, d_ready}, 32'h0);
      checkOutput("reset bus_err", {31'h0, bus_err}, 32'h0);
      checkOutput("reset gnt_d", {31'h0, gnt_d}, 32'h0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      // Both sides request together: D first, then I after one idle cycle.
      i_req = 1'b1; i_addr = 16'h0005;
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
      mem_rdata = 32'hBEEF_1234;
      step();
      checkOutput("both first mem_req", {31'h0, mem_req}, 32'h1);
      checkOutput("both first mem_addr", mem_addr, 32'h0000_0100);
      checkOutput("both first gnt_d", {31'h0, gnt_d}, 32'h1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      checkOutput("both d_ready", {31'h0, d_ready}, 32'h1);
      checkOutput("both i_ready low", {31'h0, i_ready}, 32'h0);
      checkOutput("both d_rdata", d_rdata, 32'h0);
      d_req = 1'b0;
      step();
      checkOutput("both idle gap", {31'h0, mem_req}, 32'h0);
      step();
      checkOutput("both second mem_addr", mem_addr, 32'h0000_000A);
      checkOutput("both second gnt_d", {31'h0, gnt_d}, 32'h0);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      checkOutput("both i_ready", {31'h0, i_ready}, 32'h1);
      checkOutput("both i_rdata", {16'h0, i_rdata}, 32'h0000_BEEF);
      i_req = 1'b0;
      step();

      // Starvation guard: D held with I pending wins four times, then I wins.
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
      i_req = 1'b1; i_addr = 16'h0003;
      for (int g = 0; g < 5; g++) begin
         serveOne(wasD, ok);
         if (!ok) boundExpired($sformatf("starve grant%0d", g));
         checkOutput($sformatf("starve grant%0d owner_d", g), {31'h0, wasD}, (g < 4) ? 32'h1 : 32'h0);
         if (!wasD) i_req = 1'b0;
      end
      i_req = 1'b1;
      serveOne(wasD, ok);
      if (!ok) boundExpired("starve cleared grant");
      checkOutput("starve cleared owner_d", {31'h0, wasD}, 32'h1);
      d_req = 1'b0;
      serveOne(wasD, ok);
      if (!ok) boundExpired("starve final grant");
      checkOutput("starve final owner_d", {31'h0, wasD}, 32'h0);
      i_req = 1'b0;

      // No ack at all: abort after exactly TIMEOUT busy cycles.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
      mem_rdata = 32'hDEAD_BEEF;
      cnt  = 0;
      fell = 0;
      for (int c = 0; c < 400 && !fell; c++) begin
         step();
         if (mem_req) cnt++;
         else if (cnt > 0) fell = 1;
      end
      checkOutput("timeout mem_req cycles", cnt, 255);
      checkOutput("timeout bus_err", {31'h0, bus_err}, 32'h1);
      checkOutput("timeout d_ready", {31'h0, d_ready}, 32'h1);
      checkOutput("timeout d_rdata", d_rdata, 32'h0);
      d_req   = 1'b0;
      mem_ack = 1'b1;
      step();
      checkOutput("timeout bus_err pulse", {31'h0, bus_err}, 32'h0);
      checkOutput("stray ack mem_req", {31'h0, mem_req}, 32'h0);
      step();
      checkOutput("stray ack ready", {31'h0, d_ready | i_ready}, 32'h0);
      mem_ack = 1'b0;

      // Reset during BUSY with an ack on the same edge.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      step();
      checkOutput("rst busy mem_req", {31'h0, mem_req}, 32'h1);
      mem_ack = 1'b1;
      rst     = 1'b1;
      d_req   = 1'b0;
      step();
      checkOutput("rst mem_req", {31'h0, mem_req}, 32'h0);
      checkOutput("rst d_ready", {31'h0, d_ready}, 32'h0);
      checkOutput("rst gnt_d", {31'h0, gnt_d}, 32'h0);
      checkOutput("rst mem_addr", mem_addr, 32'h0);
      rst     = 1'b0;
      mem_ack = 1'b0;
      step();
      checkOutput("post rst ready", {31'h0, d_ready | i_ready}, 32'h0);
      checkOutput("post rst mem_req", {31'h0, mem_req}, 32'h0);

      // Requester drops d_req after grant; ack arrives on the fourth busy cycle.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h77;
      busy    = 0;
      readies = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         mem_ack = 1'b0;
         if (mem_req) begin
            busy++;
            if (busy == 1) d_req = 1'b0;
            if (busy == 4) mem_ack = 1'b1;
         end
         if (d_ready) readies++;
      end
      checkOutput("drop busy cycles", busy, 4);
      checkOutput("drop d_ready pulses", readies, 1);

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
